mini_cpu_instr_sender: RTL and testbench
========================================

Name: mini_cpu_instr_sender

Overview:
Instruction source for the mini CPU. It holds a small program of packed instruction words, written by a loader port. On start it powers the CPU (ligar), then issues the program one instruction at a time. Each instruction is presented on the CPU's field outputs (opcode/src1/src2/sinalImm/Imm/dest) and strobed with enviar, paced by the CPU's ready signal. It sits between the board-level loader/switch logic and the mini CPU core.

Parameters:
DEPTH, 16, number of instruction slots in program memory (power of two)
AW, 4, address width = log2(DEPTH)
POWER_CYCLES, 4, cycles ligar is held high before the first enviar (range 1..255)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  program write strobe
wr_addr  input  AW  program slot address
wr_data  input  22  packed word {opcode[21:19], src1[18:15], src2[14:11], sinalImm[10], Imm[9:4], dest[3:0]}
prog_len  input  AW+1  number of instructions to issue, 1..DEPTH; sampled on start
start  input  1  one-cycle start request
abort  input  1  stop issuing, drop ligar
cpu_ready  input  1  CPU can accept an instruction this cycle
opcode  output  3  instruction field
src1  output  4  instruction field
src2  output  4  instruction field
sinalImm  output  1  immediate-select field
Imm  output  6  immediate field
dest  output  4  instruction field
ligar  output  1  CPU power/enable level
enviar  output  1  one-cycle instruction-valid strobe
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last instruction is accepted
pc  output  AW  index of the instruction currently presented

Behaviour:
- Reset (async): state IDLE; all outputs 0. Program memory contents are not reset.
- Writes: if wr_en && !busy, mem[wr_addr] <= wr_data. Writes while busy are ignored.
- States:
  - IDLE: on start with 1 <= prog_len <= DEPTH, latch len, pc <= 0, set ligar, cnt <= 0, go to POWER. Otherwise (including prog_len 0 or > DEPTH) start is ignored.
  - POWER: cnt++ each cycle. When cnt == POWER_CYCLES-1, go to ISSUE.
  - ISSUE: fields are driven from mem[pc] and are registered, so they are valid on the first ISSUE cycle. enviar = 1 in every ISSUE cycle where cpu_ready = 1 (registered, so enviar is seen in the following cycle with the fields unchanged). After enviar, go to GAP.
  - GAP: exactly one cycle with enviar = 0 and fields held. If pc == len-1, go to FIN; else pc++ and go to ISSUE.
  - FIN: done = 1 for one cycle, go to IDLE. ligar stays high.
- Handshake rules:
  - enviar is never high on two consecutive cycles.
  - Fields are stable from one cycle before enviar through the GAP cycle.
  - cpu_ready low in ISSUE stalls indefinitely, with fields held.
- Latency: start to first enviar = POWER_CYCLES + 2 cycles when cpu_ready is held high. Instruction-to-instruction = 3 cycles.
- abort (any state except IDLE): next state IDLE, ligar <= 0, enviar <= 0, no done. In IDLE, abort clears ligar.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- ligar: set by accepted start; cleared only by abort or rst. A start while ligar is already high still runs POWER.
- Reset mid-program: outputs return to 0 immediately (async); no partial done.
- pc never exceeds len-1. There is no wrap-around issue.

Decomposition:
- Package mini_cpu_pkg: opcode constants LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111. Also field widths, word bit offsets, and word width 22. Shared with the CPU core.
- Sub-module mini_cpu_prog_mem: DEPTH x 22 register array, synchronous write, registered read (address = pc).
- The FSM and field unpacking stay in the top module.

Test Plan:
- Reset: assert rst mid-ISSUE -> all outputs 0 asynchronously; busy=0 after release.
- Basic run, POWER_CYCLES=4, cpu_ready=1, write slot0={ADDI,1,0,1,5,2} and slot1={DISPLAY,2,0,0,0,0}, start with prog_len=2 -> ligar rises the cycle after start. enviar pulses at +6 and +9 with matching fields. done pulses at +11; ligar stays 1.
- Stall: cpu_ready=0 for 10 cycles during ISSUE of pc=0 -> no enviar and fields constant. enviar is asserted 1 cycle after cpu_ready rises.
- Boundaries: prog_len=0 and prog_len=17 -> start ignored, busy stays 0. prog_len=16 -> 16 enviar pulses, pc 0..15, then one done.
- Abort: abort in the GAP after the 3rd enviar -> IDLE next cycle, ligar=0, no done, no further enviar. start and abort in the same cycle in IDLE -> stays IDLE.
- Write while busy: wr_en to slot 0 during the run -> ignored; a rerun reissues the original word.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU and its instruction sender.
// Holds the opcode encoding, instruction field widths and bit offsets of
// the 22-bit packed instruction word, the sender FSM state type, and a
// helper that packs the fields into a word.
package mini_cpu_pkg;

  localparam int WORD_W   = 22;
  localparam int OPC_W    = 3;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 6;

  localparam int OPC_LSB  = 19;
  localparam int SRC1_LSB = 15;
  localparam int SRC2_LSB = 11;
  localparam int SIMM_BIT = 10;
  localparam int IMM_LSB  = 4;
  localparam int DEST_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    LOAD    = 3'b000,
    ADD     = 3'b001,
    ADDI    = 3'b010,
    SUB     = 3'b011,
    SUBI    = 3'b100,
    MUL     = 3'b101,
    CLEAR   = 3'b110,
    DISPLAY = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POWER,
    S_ISSUE,
    S_SEND,
    S_GAP,
    S_FIN
  } sender_state_e;

  function automatic logic [WORD_W-1:0] pack_instr(
    input opcode_e          op,
    input logic [REG_W-1:0] s1,
    input logic [REG_W-1:0] s2,
    input logic             simm,
    input logic [IMM_W-1:0] imm,
    input logic [REG_W-1:0] d
  );
    return {op, s1, s2, simm, imm, d};
  endfunction

endpackage

// File: rtl/mini_cpu_prog_mem.sv
// Program memory for the instruction sender.
// DEPTH x WORD_W register array with a synchronous write port and a
// registered, enabled read port. The array itself is not reset; only the
// read register is, so the CPU field outputs come up as zero.
// Ports: clk, rst (async, active-high), wr_en/wr_addr/wr_data (write port),
//        rd_en/rd_addr (read request), rd_data (registered read word).
module mini_cpu_prog_mem
  import mini_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mini_cpu_instr_sender.sv
// Instruction source for the mini CPU.
// A loader writes packed instruction words into program memory while idle.
// On start the block raises ligar, waits POWER_CYCLES, then issues prog_len
// instructions one at a time: each is presented on the field outputs, then
// strobed with a single-cycle enviar once cpu_ready is seen, followed by a
// one-cycle gap. done pulses once after the last instruction; abort stops
// issuing and drops ligar.
// Ports: clk, rst (async, active-high); wr_en/wr_addr/wr_data (loader);
//        prog_len/start/abort (control); cpu_ready (CPU handshake);
//        opcode/src1/src2/sinalImm/Imm/dest (instruction fields);
//        ligar, enviar, busy, done, pc (status/strobes).
module mini_cpu_instr_sender
  import mini_cpu_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int POWER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              cpu_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  src1,
  output logic [REG_W-1:0]  src2,
  output logic              sinalImm,
  output logic [IMM_W-1:0]  Imm,
  output logic [REG_W-1:0]  dest,
  output logic              ligar,
  output logic              enviar,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc
);

  localparam logic [AW:0] LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
  localparam logic [7:0]  CNT_LAST = 8'(POWER_CYCLES - 1);

  sender_state_e     state, state_nxt;
  logic [AW-1:0]     pc_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [AW:0]       len, len_nxt;
  logic              ligar_nxt;
  logic              len_ok;
  logic              last_instr;
  logic              rd_en;
  logic [WORD_W-1:0] word_p0;

  assign len_ok     = (prog_len != '0) && (prog_len <= LEN_MAX);
  assign last_instr = ({1'b0, pc} == (len - LEN_ONE));

  // Fetch the word on the edge that enters ISSUE, addressed by the pc that
  // ISSUE will hold, so fields are valid on the first ISSUE cycle and stay
  // put through SEND and GAP.
  assign rd_en = (state_nxt == S_ISSUE) && (state != S_ISSUE);

  mini_cpu_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (pc_nxt),
    .rd_data (word_p0)
  );

  assign opcode   = word_p0[OPC_LSB  +: OPC_W];
  assign src1     = word_p0[SRC1_LSB +: REG_W];
  assign src2     = word_p0[SRC2_LSB +: REG_W];
  assign sinalImm = word_p0[SIMM_BIT];
  assign Imm      = word_p0[IMM_LSB  +: IMM_W];
  assign dest     = word_p0[DEST_LSB +: REG_W];

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    len_nxt   = len;
    ligar_nxt = ligar;
    unique case (state)
      S_IDLE: begin
        if (start && !abort && len_ok) begin
          len_nxt   = prog_len;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          ligar_nxt = 1'b1;
          state_nxt = S_POWER;
        end
      end
      S_POWER: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == CNT_LAST) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (cpu_ready) state_nxt = S_SEND;
      end
      S_SEND: state_nxt = S_GAP;
      S_GAP: begin
        if (last_instr) begin
          state_nxt = S_FIN;
        end else begin
          pc_nxt    = pc + AW'(1);
          state_nxt = S_ISSUE;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort overrides everything, including a start in the same cycle
    if (abort) begin
      state_nxt = S_IDLE;
      ligar_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      cnt    <= '0;
      len    <= '0;
      ligar  <= 1'b0;
      enviar <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      len    <= len_nxt;
      ligar  <= ligar_nxt;
      enviar <= (state_nxt == S_SEND);
      done   <= (state_nxt == S_FIN);
    end
  end

endmodule

// File: tb/tb_mini_cpu_instr_sender.sv
module tb_mini_cpu_instr_sender;
  import mini_cpu_pkg::*;

  localparam int P    = 4;
  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [21:0] wr_data = '0;
  logic [4:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cpu_ready = 1'b0;
  logic [2:0]  opcode;
  logic [3:0]  src1, src2, dest, pc;
  logic        sinalImm;
  logic [5:0]  Imm;
  logic        ligar, enviar, busy, done;

  mini_cpu_instr_sender #(.DEPTH(16), .AW(4), .POWER_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .abort(abort), .cpu_ready(cpu_ready),
    .opcode(opcode), .src1(src1), .src2(src2), .sinalImm(sinalImm), .Imm(Imm),
    .dest(dest), .ligar(ligar), .enviar(enviar), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit          rdy       [MAXC];
  logic        obs_env   [MAXC];
  logic        obs_done  [MAXC];
  logic        obs_ligar [MAXC];
  logic        obs_busy  [MAXC];
  logic [21:0] obs_word  [MAXC];
  logic [3:0]  obs_pc    [MAXC];
  logic [21:0] mem_m     [16];
  int          env_cyc   [16];
  int          done_cyc;
  bit          ligar_m = 1'b0;

  task automatic write_slot(input logic [3:0] a, input logic [21:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Cycle 0 is the cycle in which start is high; everything is sampled at negedge.
  task automatic capture(input int len, input int ncyc, input int abort_at,
                         input int wr_at, input logic [3:0] wa, input logic [21:0] wd);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0); prog_len = 5'(len); cpu_ready = rdy[c];
      abort = (c == abort_at);
      wr_en = (c == wr_at); wr_addr = wa; wr_data = wd;
      @(negedge clk);
      obs_env[c] = enviar; obs_done[c] = done; obs_ligar[c] = ligar; obs_busy[c] = busy;
      obs_word[c] = {opcode, src1, src2, sinalImm, Imm, dest}; obs_pc[c] = pc;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; cpu_ready = 1'b0;
  endtask

  // Transaction-level timing: ISSUE opens P+1 cycles after start; an
  // instruction is strobed the cycle after the first ready cycle at or after
  // ISSUE opens; the next ISSUE opens two cycles after that strobe.
  function automatic void model(input int len);
    int t;
    t = P + 1;
    for (int i = 0; i < len; i++) begin
      while (t < MAXC - 4 && !rdy[t]) t++;
      env_cyc[i] = t + 1;
      t = t + 3;
    end
    done_cyc = env_cyc[len-1] + 2;
  endfunction

  task automatic test_reset();
    logic [32:0] all_out;
    rst = 1'b1; #2;
    all_out = {opcode, src1, src2, sinalImm, Imm, dest, ligar, enviar, busy, done, pc};
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_init: got %0h want 0", all_out); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b0;
    capture(2, P + 4, -1, -1, 4'd0, 22'd0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1; #1;
    all_out = {opcode, src1, src2, sinalImm, Imm, dest, ligar, enviar, busy, done, pc};
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_mid_issue: got %0h want 0", all_out); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, ligar, done} !== 3'b000) begin n_bad++; $display("FAIL reset_release: got %b want 000", {busy, ligar, done}); end
    ligar_m = 1'b0;
  endtask

  task automatic test_basic();
    logic [21:0] w0, w1;
    int ne, nd;
    w0 = pack_instr(ADDI, 4'd1, 4'd0, 1'b1, 6'd5, 4'd2);
    w1 = pack_instr(DISPLAY, 4'd2, 4'd0, 1'b0, 6'd0, 4'd0);
    write_slot(4'd0, w0);
    write_slot(4'd1, w1);
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    capture(2, 14, -1, -1, 4'd0, 22'd0);
    n_cmp++; if (obs_ligar[0] !== 1'b0 || obs_ligar[1] !== 1'b1) begin n_bad++; $display("FAIL basic_ligar_rise: got %b%b want 01", obs_ligar[0], obs_ligar[1]); end
    n_cmp++; if (obs_env[6] !== 1'b1 || obs_word[6] !== w0 || obs_pc[6] !== 4'd0) begin n_bad++; $display("FAIL basic_env0: got env=%b word=%h pc=%0d want 1 %h 0", obs_env[6], obs_word[6], obs_pc[6], w0); end
    n_cmp++; if (obs_env[9] !== 1'b1 || obs_word[9] !== w1 || obs_pc[9] !== 4'd1) begin n_bad++; $display("FAIL basic_env1: got env=%b word=%h pc=%0d want 1 %h 1", obs_env[9], obs_word[9], obs_pc[9], w1); end
    n_cmp++; if (obs_done[11] !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", obs_done[11]); end
    ne = 0; nd = 0;
    for (int c = 0; c < 14; c++) begin ne += int'(obs_env[c]); nd += int'(obs_done[c]); end
    n_cmp++; if (ne != 2 || nd != 1) begin n_bad++; $display("FAIL basic_counts: got env=%0d done=%0d want 2 1", ne, nd); end
    n_cmp++; if (obs_ligar[13] !== 1'b1 || obs_busy[13] !== 1'b0) begin n_bad++; $display("FAIL basic_after: got ligar=%b busy=%b want 1 0", obs_ligar[13], obs_busy[13]); end
    ligar_m = 1'b1;
  endtask

  task automatic test_stall();
    for (int c = 0; c < MAXC; c++) rdy[c] = (c < 5 || c >= 15);
    capture(1, 22, -1, -1, 4'd0, 22'd0);
    for (int c = 5; c <= 15; c++) begin
      n_cmp++; if (obs_env[c] !== 1'b0 || obs_word[c] !== mem_m[0]) begin n_bad++; $display("FAIL stall_hold c=%0d: got env=%b word=%h want 0 %h", c, obs_env[c], obs_word[c], mem_m[0]); end
    end
    n_cmp++; if (obs_env[16] !== 1'b1 || obs_word[16] !== mem_m[0]) begin n_bad++; $display("FAIL stall_release: got env=%b word=%h want 1 %h", obs_env[16], obs_word[16], mem_m[0]); end
    n_cmp++; if (obs_done[18] !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", obs_done[18]); end
  endtask

  task automatic test_bad_len(input int len);
    int nb, ne, nl;
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    capture(len, 10, -1, -1, 4'd0, 22'd0);
    nb = 0; ne = 0; nl = 0;
    for (int c = 0; c < 10; c++) begin
      nb += int'(obs_busy[c]); ne += int'(obs_env[c]); nl += int'(obs_ligar[c] !== ligar_m);
    end
    n_cmp++; if (nb != 0 || ne != 0 || nl != 0) begin n_bad++; $display("FAIL bad_len_%0d: got busy=%0d env=%0d ligar_changes=%0d want 0 0 0", len, nb, ne, nl); end
  endtask

  task automatic test_random_run(input int len, input bit rnd);
    int ncyc, c;
    bit  exp_env;
    for (int a = 0; a < 16; a++) write_slot(4'(a), 22'($urandom));
    for (int k = 0; k < MAXC; k++) rdy[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    model(len);
    ncyc = done_cyc + 3;
    if (ncyc > MAXC) ncyc = MAXC;
    capture(len, ncyc, -1, -1, 4'd0, 22'd0);
    for (int k = 0; k < ncyc; k++) begin
      exp_env = 1'b0;
      for (int i = 0; i < len; i++) if (env_cyc[i] == k) exp_env = 1'b1;
      n_cmp++; if (obs_env[k] !== exp_env) begin n_bad++; $display("FAIL run_enviar len=%0d c=%0d: got %b want %b", len, k, obs_env[k], exp_env); end
      n_cmp++; if (obs_done[k] !== (k == done_cyc)) begin n_bad++; $display("FAIL run_done len=%0d c=%0d: got %b want %b", len, k, obs_done[k], k == done_cyc); end
      n_cmp++; if (obs_busy[k] !== (k >= 1 && k <= done_cyc)) begin n_bad++; $display("FAIL run_busy len=%0d c=%0d: got %b", len, k, obs_busy[k]); end
      n_cmp++; if (obs_ligar[k] !== ((k == 0) ? ligar_m : 1'b1)) begin n_bad++; $display("FAIL run_ligar len=%0d c=%0d: got %b", len, k, obs_ligar[k]); end
    end
    for (int i = 0; i < len; i++) begin
      for (int d = -1; d <= 1; d++) begin
        c = env_cyc[i] + d;
        if (c < ncyc) begin
          n_cmp++; if (obs_word[c] !== mem_m[i] || obs_pc[c] !== 4'(i)) begin n_bad++; $display("FAIL run_fields len=%0d i=%0d c=%0d: got word=%h pc=%0d want %h %0d", len, i, c, obs_word[c], obs_pc[c], mem_m[i], i); end
        end
      end
    end
    ligar_m = 1'b1;
  endtask

  task automatic test_abort();
    int nb, ne, nd, nl;
    for (int a = 0; a < 8; a++) write_slot(4'(a), 22'($urandom));
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    capture(5, 30, 13, -1, 4'd0, 22'd0);
    n_cmp++; if (obs_env[12] !== 1'b1 || obs_busy[13] !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got env12=%b busy13=%b want 1 1", obs_env[12], obs_busy[13]); end
    nb = 0; ne = 0; nd = 0; nl = 0;
    for (int c = 14; c < 30; c++) begin
      nb += int'(obs_busy[c]); ne += int'(obs_env[c]); nd += int'(obs_done[c]); nl += int'(obs_ligar[c]);
    end
    n_cmp++; if (nb + ne + nd + nl != 0) begin n_bad++; $display("FAIL abort_after: got busy=%0d env=%0d done=%0d ligar=%0d want all 0", nb, ne, nd, nl); end
    ligar_m = 1'b0;
    capture(3, 10, 0, -1, 4'd0, 22'd0);
    nb = 0; nl = 0;
    for (int c = 1; c < 10; c++) begin nb += int'(obs_busy[c]); nl += int'(obs_ligar[c]); end
    n_cmp++; if (nb != 0 || nl != 0) begin n_bad++; $display("FAIL start_abort_same: got busy=%0d ligar=%0d want 0 0", nb, nl); end
  endtask

  task automatic test_write_busy();
    logic [21:0] orig;
    orig = mem_m[0];
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    capture(1, 12, -1, 3, 4'd0, ~orig);
    n_cmp++; if (obs_env[6] !== 1'b1 || obs_word[6] !== orig) begin n_bad++; $display("FAIL wr_busy_run1: got env=%b word=%h want 1 %h", obs_env[6], obs_word[6], orig); end
    capture(1, 12, -1, -1, 4'd0, 22'd0);
    n_cmp++; if (obs_env[6] !== 1'b1 || obs_word[6] !== orig) begin n_bad++; $display("FAIL wr_busy_rerun: got env=%b word=%h want 1 %h", obs_env[6], obs_word[6], orig); end
    ligar_m = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_len(0);
    test_bad_len(17);
    test_random_run(16, 1'b0);
    test_random_run(16, 1'b1);
    for (int r = 0; r < 6; r++) test_random_run($urandom_range(1, 16), 1'b1);
    test_abort();
    test_write_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
